// File: rtl/snes_rom_stream_reader_pkg.sv
// Shared types and default widths for the cartridge ROM stream reader.
// The reader FSM walks through IDLE -> ACCESS -> OUTPUT -> ... -> DONE.
package snes_rom_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_W_DEF  = 24;
  localparam int WS_W_DEF   = 3;
  localparam int CHECKSUM_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_OUTPUT,
    ST_DONE
  } state_e;

  // Running sum wraps modulo 2^CHECKSUM_W; the caller zero-extends the byte.
  function automatic logic [CHECKSUM_W-1:0] checksum_add(
    input logic [CHECKSUM_W-1:0] sum,
    input logic [CHECKSUM_W-1:0] value
  );
    return sum + value;
  endfunction

endpackage

// File: rtl/snes_rom_stream_reader_if.sv
// Control, cartridge-bus and byte-stream signals of the ROM stream reader.
// The master modport is the reader itself; slave is the system/cartridge side.
interface snes_rom_stream_reader_if
  import snes_rom_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int WS_W   = WS_W_DEF
);

  logic                  start;
  logic                  abort;
  logic [ADDR_W-1:0]     base_addr;
  logic [LEN_W-1:0]      length;
  logic [WS_W-1:0]       wait_states;

  logic [ADDR_W-1:0]     rom_addr;
  logic [DATA_W-1:0]     rom_data;
  logic                  rom_oe_n;

  logic [DATA_W-1:0]     out_data;
  logic                  out_valid;
  logic                  out_ready;

  logic                  busy;
  logic                  done;
  logic [CHECKSUM_W-1:0] checksum;

  modport master (
    input  start, abort, base_addr, length, wait_states,
    input  rom_data, out_ready,
    output rom_addr, rom_oe_n, out_data, out_valid, busy, done, checksum
  );

  modport slave (
    output start, abort, base_addr, length, wait_states,
    output rom_data, out_ready,
    input  rom_addr, rom_oe_n, out_data, out_valid, busy, done, checksum
  );

endinterface

// File: rtl/snes_rom_wait_timer.sv
// Counts access cycles for one ROM byte; expire marks the cycle whose
// count equals the programmed number of wait states.
module snes_rom_wait_timer #(
  parameter int WS_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            enable,
  input  logic [WS_W-1:0] limit,
  output logic            expire
);

  logic [WS_W-1:0] count_q;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + WS_W'(1);
    end
  end

  assign expire = (count_q == limit);

endmodule

// File: rtl/snes_rom_stream_reader.sv
// Reads a window of cartridge ROM with programmable wait states, streams each
// byte over valid/ready and keeps a 16-bit running checksum of accepted bytes.
module snes_rom_stream_reader
  import snes_rom_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int WS_W   = WS_W_DEF
) (
  input logic                      clk,
  input logic                      reset,
  snes_rom_stream_reader_if.master bus
);

  state_e                state_q, state_d;

  logic [ADDR_W-1:0]     addr_q;
  logic [LEN_W-1:0]      remaining_q;
  logic [WS_W-1:0]       ws_q;
  logic [DATA_W-1:0]     out_data_q;
  logic                  out_valid_q;
  logic [CHECKSUM_W-1:0] checksum_q;

  logic                  handshake;
  logic                  last_byte;
  logic                  timer_clear;
  logic                  timer_enable;
  logic                  timer_expire;
  logic                  rom_oe_n_d;
  logic                  busy_d;
  logic                  done_d;

  assign handshake    = out_valid_q & bus.out_ready;
  assign last_byte    = (remaining_q == LEN_W'(1));
  assign timer_enable = (state_q == ST_ACCESS);
  assign timer_clear  = (state_q != ST_ACCESS);

  snes_rom_wait_timer #(
    .WS_W (WS_W)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .limit  (ws_q),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    rom_oe_n_d = 1'b1;
    busy_d     = (state_q != ST_IDLE);
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (bus.length == '0) ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        rom_oe_n_d = 1'b0;
        if (timer_expire) begin
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (handshake) begin
          state_d = last_byte ? ST_DONE : ST_ACCESS;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything, including a start seen in IDLE.
    if (bus.abort) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      ws_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      checksum_q  <= '0;
    end else begin
      // A byte handed over in the same cycle as an abort still counts.
      if (handshake) begin
        checksum_q <= checksum_add(checksum_q, CHECKSUM_W'(out_data_q));
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            checksum_q <= '0;
            if (bus.length != '0) begin
              addr_q      <= bus.base_addr;
              remaining_q <= bus.length;
              ws_q        <= bus.wait_states;
            end
          end
        end
        ST_ACCESS: begin
          if (timer_expire && !bus.abort) begin
            out_data_q  <= bus.rom_data;
            out_valid_q <= 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (handshake) begin
            out_valid_q <= 1'b0;
            if (!last_byte && !bus.abort) begin
              addr_q      <= addr_q + ADDR_W'(1);
              remaining_q <= remaining_q - LEN_W'(1);
            end
          end
        end
        default: ;
      endcase

      if (bus.abort) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rom_addr  = addr_q;
  assign bus.rom_oe_n  = rom_oe_n_d;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_d;
  assign bus.done      = done_d;
  assign bus.checksum  = checksum_q;

endmodule
